// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 keypad scanner: one-hot drive/row
// patterns, the position-to-hex key map, scan-result and debounce-state enums.
package keypad_pkg;

  localparam logic [3:0] COL_ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  localparam logic [3:0] ROW_ONEHOT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Indexed by col*4 + row.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'hE,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } scan_res_e;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } deb_state_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus decoded key event outputs; master is the scanner side,
// slave is the keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic       key_release;
  logic       multi_err;

  modport master (
    input  rows,
    output cols, key, key_valid, key_held, key_release, multi_err
  );

  modport slave (
    output rows,
    input  cols, key, key_valid, key_held, key_release, multi_err
  );
endinterface

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk from d to q.
// Backpressure: none; free-running sampler.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: 4x4 keypad column scanner with full-scan debounce and key events.
// Latency: event pulses one clk after the deciding scan end (scan = 4*SCAN_DIV clk).
// Backpressure: none; events are fire-and-forget pulses, key/key_held are levels.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0] rows_s;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.rows),
    .q   (rows_s)
  );

  // ---------------- column scan ----------------
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [3:0]       cols_q;
  logic [11:0]      samp;
  logic             sample_now;
  logic             scan_end;

  assign sample_now = (div_cnt == DIV_LAST);
  assign scan_end   = sample_now && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
      cols_q  <= COL_ONEHOT[0];
      samp    <= '0;
    end else if (sample_now) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      cols_q  <= COL_ONEHOT[col_idx + 2'd1];
      case (col_idx)
        2'd0:    samp[3:0]  <= rows_s;
        2'd1:    samp[7:4]  <= rows_s;
        2'd2:    samp[11:8] <= rows_s;
        default: ;
      endcase
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Column 3 is evaluated straight from the synchronizer on its sample cycle.
  logic [15:0] matrix;
  logic [4:0]  ones;
  logic [3:0]  hit_key;
  scan_res_e   res;

  assign matrix = {rows_s, samp};

  always_comb begin
    ones    = '0;
    hit_key = '0;
    res     = RES_NONE;
    for (int i = 0; i < 16; i++) begin
      if (matrix[i]) begin
        ones    = ones + 5'd1;
        hit_key = KEY_MAP[i];
      end
    end
    if (ones == 5'd1)
      res = RES_KEY;
    else if (ones > 5'd1)
      res = RES_MULTI;
  end

  // ---------------- debounce FSM ----------------
  deb_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic [3:0]       key_q, key_n;
  logic             held_q, held_n;
  logic             valid_q, valid_n;
  logic             release_q, release_n;
  logic             multi_q, multi_n;

  assign cnt_inc = (cnt >= DEB_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RELEASED;
      cnt       <= '0;
      cand      <= '0;
      key_q     <= '0;
      held_q    <= 1'b0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_q     <= key_n;
      held_q    <= held_n;
      valid_q   <= valid_n;
      release_q <= release_n;
      multi_q   <= multi_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cand_n    = cand;
    key_n     = key_q;
    held_n    = held_q;
    valid_n   = 1'b0;
    release_n = 1'b0;
    multi_n   = scan_end && (res == RES_MULTI);
    if (scan_end) begin
      case (state)
        ST_RELEASED: begin
          if (res == RES_KEY) begin
            state_n = ST_PRESS_WAIT;
            cand_n  = hit_key;
            cnt_n   = CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (res == RES_KEY && hit_key == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_n = ST_PRESSED;
              key_n   = cand;
              held_n  = 1'b1;
              valid_n = 1'b1;
            end
          end else if (res == RES_KEY) begin
            cand_n = hit_key;
            cnt_n  = CNT_ONE;
          end else begin
            state_n = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          // No rollover: other keys are ignored until a debounced release.
          if (res == RES_NONE) begin
            state_n = ST_RELEASE_WAIT;
            cnt_n   = CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (res == RES_NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_MAX) begin
              state_n   = ST_RELEASED;
              held_n    = 1'b0;
              release_n = 1'b1;
            end
          end else begin
            state_n = ST_PRESSED;
          end
        end
        default: state_n = ST_RELEASED;
      endcase
    end
  end

  assign kp.cols        = cols_q;
  assign kp.key         = key_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_held    = held_q;
  assign kp.key_release = release_q;
  assign kp.multi_err   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a table of press patterns with expected
// events per block of scans, plus hand-written reset sequences.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEB_SCANS(DS)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // Pressed-key mask indexed by col*4 + row; the keypad closes row r when
  // column c is driven and key (c,r) is down.
  logic [15:0] pressed = '0;
  always_comb begin
    kif.rows = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (kif.cols[c] && pressed[c*4 + r]) kif.rows[r] = 1'b1;
  end

  int checks   = 0;
  int failures = 0;
  int pv = 0, pr = 0, pm = 0, mistimed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs until the cycle after the next scan end (cols 1000 -> 0001), counting
  // pulse cycles; pulses are only legal in that boundary cycle.
  task automatic wait_scan();
    logic [3:0] prev;
    logic       boundary;
    int         n;
    prev     = kif.cols;
    boundary = 1'b0;
    n        = 0;
    while (!boundary && n < 100) begin
      @(negedge clk);
      n++;
      boundary = (prev == 4'b1000) && (kif.cols == 4'b0001);
      if (kif.key_valid)   pv++;
      if (kif.key_release) pr++;
      if (kif.multi_err)   pm++;
      if ((kif.key_valid || kif.key_release || kif.multi_err) && !boundary) mistimed++;
      prev = kif.cols;
    end
    if (!boundary) check("scan_timeout", 0, 1);
  endtask

  task automatic do_scans(input logic [15:0] press, input int n);
    pressed = press;
    for (int s = 0; s < n; s++) wait_scan();
  endtask

  typedef struct {
    logic [15:0] press;
    int          nscans;
    int          exp_v;
    int          exp_r;
    int          exp_m;
    logic [3:0]  exp_key;
    logic        exp_held;
  } vec_t;

  function automatic vec_t mk(logic [15:0] p, int n, int v, int r, int m,
                              logic [3:0] k, logic h);
    vec_t t;
    t.press = p; t.nscans = n; t.exp_v = v; t.exp_r = r; t.exp_m = m;
    t.exp_key = k; t.exp_held = h;
    return t;
  endfunction

  localparam logic [15:0] K1 = 16'h0001, K5 = 16'h0020, K9 = 16'h0400;
  localparam logic [15:0] K6 = 16'h0200, KC = 16'h4000, KE = 16'h0008;
  localparam logic [15:0] KD = 16'h8000, K2 = 16'h0010, K8 = 16'h0040;
  localparam logic [15:0] K3 = 16'h0100, NONE = 16'h0000;

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(NONE,    1, 0, 0, 0, 4'h0, 1'b0));
    tbl.push_back(mk(K5,      3, 1, 0, 0, 4'h5, 1'b1));
    tbl.push_back(mk(NONE,    3, 0, 1, 0, 4'h5, 1'b0));
    tbl.push_back(mk(K9,      2, 0, 0, 0, 4'h5, 1'b0));
    tbl.push_back(mk(NONE,    1, 0, 0, 0, 4'h5, 1'b0));
    tbl.push_back(mk(K9,      4, 1, 0, 0, 4'h9, 1'b1));
    tbl.push_back(mk(NONE,    3, 0, 1, 0, 4'h9, 1'b0));
    tbl.push_back(mk(K1 | K6, 3, 0, 0, 3, 4'h9, 1'b0));
    tbl.push_back(mk(NONE,    1, 0, 0, 0, 4'h9, 1'b0));
    tbl.push_back(mk(KC,      3, 1, 0, 0, 4'hC, 1'b1));
    tbl.push_back(mk(NONE,    1, 0, 0, 0, 4'hC, 1'b1));
    tbl.push_back(mk(KC,      1, 0, 0, 0, 4'hC, 1'b1));
    tbl.push_back(mk(NONE,    3, 0, 1, 0, 4'hC, 1'b0));
    tbl.push_back(mk(KE,      3, 1, 0, 0, 4'hE, 1'b1));
    tbl.push_back(mk(KE | KD, 1, 0, 0, 1, 4'hE, 1'b1));
    tbl.push_back(mk(KD,      3, 0, 0, 0, 4'hE, 1'b1));
    tbl.push_back(mk(NONE,    3, 0, 1, 0, 4'hE, 1'b0));
    tbl.push_back(mk(K2,      2, 0, 0, 0, 4'hE, 1'b0));
    tbl.push_back(mk(K8,      3, 1, 0, 0, 4'h8, 1'b1));
    tbl.push_back(mk(NONE,    3, 0, 1, 0, 4'h8, 1'b0));

    // Reset state and first column rotation.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cols", int'(kif.cols), 1);
    check("rst_key", int'(kif.key), 0);
    check("rst_held", int'(kif.key_held), 0);
    check("rst_pulses", int'({kif.key_valid, kif.key_release, kif.multi_err}), 0);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("cols_hold_7clk", int'(kif.cols), 1);
    @(negedge clk);
    check("cols_rotate_8clk", int'(kif.cols), 2);
    wait_scan();

    for (int i = 0; i < tbl.size(); i++) begin
      pv = 0; pr = 0; pm = 0;
      do_scans(tbl[i].press, tbl[i].nscans);
      check($sformatf("vec%0d_key_valid_cnt", i), pv, tbl[i].exp_v);
      check($sformatf("vec%0d_key_release_cnt", i), pr, tbl[i].exp_r);
      check($sformatf("vec%0d_multi_err_cnt", i), pm, tbl[i].exp_m);
      check($sformatf("vec%0d_key", i), int'(kif.key), int'(tbl[i].exp_key));
      check($sformatf("vec%0d_key_held", i), int'(kif.key_held), int'(tbl[i].exp_held));
    end

    // Reset in the middle of the second PRESS_WAIT scan of "3".
    pv = 0; pr = 0; pm = 0;
    do_scans(K3, 1);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (kif.key_valid || kif.key_release || kif.multi_err) pv++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulses_during", int'({kif.key_valid, kif.key_release, kif.multi_err}), 0);
    check("midrst_cols", int'(kif.cols), 1);
    check("midrst_key", int'(kif.key), 0);
    rst = 1'b0;
    do_scans(K3, 2);
    check("midrst_no_valid_2scans", pv, 0);
    check("midrst_held_2scans", int'(kif.key_held), 0);
    do_scans(K3, 1);
    check("midrst_valid_3rd", pv, 1);
    check("midrst_key3", int'(kif.key), 3);
    check("midrst_held3", int'(kif.key_held), 1);
    do_scans(NONE, 3);
    check("midrst_release", pr, 1);
    check("midrst_key_kept", int'(kif.key), 3);
    check("multi_during_midrst", pm, 0);

    check("pulse_timing", mistimed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, 1000, clocks each column is driven per scan (legal range >= 4).
REQ-002 DEB_SCANS, 4, consecutive identical full-scan results needed to accept a press or release (legal range >= 2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rows  input  4  asynchronous keypad row lines, active-high; bit0 = top row.
REQ-006 cols  output  4  one-hot column drive, active-high; bit0 = left column.
REQ-007 key  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse on key acceptance.
REQ-009 key_held  output  1  level, high while an accepted key is still pressed.
REQ-010 key_release  output  1  one-cycle pulse on accepted release.
REQ-011 multi_err  output  1  one-cycle pulse when a scan sees more than one key.

Function
REQ-012 rows SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Column counter SHALL run 0..SCAN_DIV-1 per column, with column index 0->1->2->3->0; cols = one-hot(index), registered; full scan = 4*SCAN_DIV clocks.
REQ-014 Synchronized rows SHALL be sampled at counter == SCAN_DIV-1 for the current column; the 4x4 sample matrix is evaluated at the column-3 sample cycle ("scan end").
REQ-015 Key map: col0 rows0..3 = 1,4,7,E; col1 = 2,5,8,0; col2 = 3,6,9,F; col3 = A,B,C,D.
REQ-016 Scan result: NONE if all 16 samples are 0; KEY(k) if exactly one sample is 1; MULTI otherwise.
REQ-017 At scan end, a MULTI result SHALL pulse multi_err in the following cycle.
REQ-018 Debounce FSM states are RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT; it SHALL advance only at scan end.
REQ-019 RELEASED: on KEY(k), go to PRESS_WAIT with cand=k and cnt=1; on NONE or MULTI, stay.
REQ-020 PRESS_WAIT: on KEY(cand), cnt+1; when cnt reaches DEB_SCANS, go to PRESSED, set key=cand and key_held=1, and pulse key_valid.
REQ-021 PRESS_WAIT: on KEY(j) with j != cand, set cand=j and cnt=1; on NONE or MULTI, go to RELEASED.
REQ-022 PRESSED: on NONE, go to RELEASE_WAIT with cnt=1; on KEY (any) or MULTI, stay; there is no rollover, so a new key requires a release first.
REQ-023 RELEASE_WAIT: on NONE, cnt+1; when cnt reaches DEB_SCANS, go to RELEASED, clear key_held and pulse key_release; on KEY or MULTI, return to PRESSED with no pulse.
REQ-024 key_valid, key_release and multi_err SHALL be registered and high exactly one cycle, the cycle after the deciding scan end.
REQ-025 key SHALL hold its value through release until the next acceptance.
REQ-026 cnt SHALL saturate at DEB_SCANS and never wrap.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL set cols=0001, column counter=0, index=0, FSM=RELEASED, cnt=0, cand=0, key=0, key_held=0, all pulses=0 and synchronizer flops=0.
REQ-028 Reset asserted mid-scan or mid-debounce SHALL discard partial samples and emit no pulse in that cycle or the next.

Structure
REQ-029 A shared package keypad_pkg SHALL hold the one-hot row/column constants, the 16-entry key map, the scan-result enum {NONE, KEY, MULTI} and the debounce-state enum.
REQ-030 One sub-module sync_2ff (parameterized width, here 4) SHALL be used for row synchronization; all other logic SHALL be inline.

Verification (SCAN_DIV=8, DEB_SCANS=3, scan=32 clk)
REQ-031 Reset: assert rst for 2 clk -> cols=0001, key=0, key_held=0, no pulses; cols rotates 0001->0010 exactly 8 clk after rst deasserts.
REQ-032 Press "5" (rows=0010 only while cols=0010) for 3 scans -> exactly one key_valid after the third scan end, key=5, key_held=1.
REQ-033 Bounce: "9" for 2 scans, NONE for 1, "9" for 4 -> a single key_valid after scan 6, key=9.
REQ-034 Keys "1" and "6" held together -> multi_err pulse every scan, no key_valid, FSM stays RELEASED.
REQ-035 After "C" is accepted: NONE for 1 scan then "C" again -> no key_release; NONE for 3 scans -> key_release pulse, key_held=0, key stays C.
REQ-036 rst pulsed during the 2nd PRESS_WAIT scan of "3" -> no key_valid; "3" then needs 3 fresh scans to be accepted.
